// File: rtl/digit_collector_32x2_pkg.sv
// Shared definitions for the 32-slot, 2-bit digit collector.
// Contents:
//   DIGIT_W, SLOTS, IDX_W, WORD_W - geometry of the slot register
//   state_t                       - collector FSM encoding
package digit_collector_32x2_pkg;

    localparam int DIGIT_W = 2;                 // width of one digit slot
    localparam int SLOTS   = 32;                // number of slots
    localparam int IDX_W   = 5;                 // slot index width, log2(SLOTS)
    localparam int WORD_W  = DIGIT_W * SLOTS;   // assembled word width

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        FULL    = 2'b10
    } state_t;

endpackage : digit_collector_32x2_pkg

// File: rtl/digit_collector_32x2_demux.sv
// demux1to32_2bit: write-side decoder for the slot register. It is the
// counterpart of the 32-to-1 2-bit read selector. Each slot receives a
// 2-bit load enable, so the enables can be used directly as a bit mask.
// Ports:
//   idx     in  5   slot to be loaded
//   en      in  1   load request
//   load_en out 64  per-slot enables; slot k drives bits [2k+1:2k]
module demux1to32_2bit
    import digit_collector_32x2_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    input  logic              en,
    output logic [WORD_W-1:0] load_en
);

    // NOTE: assign a default before any conditional assignment in
    // combinational logic, otherwise unassigned paths infer latches.
    always_comb begin
        load_en = '0;
        for (int k = 0; k < SLOTS; k++) begin
            load_en[k*DIGIT_W +: DIGIT_W] = {DIGIT_W{en && (idx == IDX_W'(k))}};
        end
    end

endmodule : demux1to32_2bit

// File: rtl/digit_collector_32x2.sv
// digit_collector_32x2: collects 32 two-bit digits into one 64-bit word.
// A start pulse clears the word and begins a collection; each accepted
// digit is written into slot wr_idx; once slot 31 is written the word is
// presented with out_valid until the consumer takes it.
// Ports:
//   clk       in  1   clock, rising edge
//   rst_n     in  1   asynchronous active-low reset
//   start     in  1   clear and begin (ignored while a full word waits)
//   in_valid  in  1   in_data carries a digit
//   in_data   in  2   digit for slot wr_idx
//   in_ready  out 1   digit accepted this cycle (COLLECT)
//   out_valid out 1   word complete and stable (FULL)
//   out_ready in  1   consumer takes out
//   out       out 64  assembled word, slot k at bits [2k+1:2k]
//   wr_idx    out 5   next slot to be written
module digit_collector_32x2
    import digit_collector_32x2_pkg::*;
#(
    // Only the defaults are supported; they fix the 5-bit index.
    parameter int DIGIT_W = digit_collector_32x2_pkg::DIGIT_W,
    parameter int SLOTS   = digit_collector_32x2_pkg::SLOTS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [DIGIT_W-1:0]         in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIGIT_W*SLOTS-1:0]   out,
    output logic [IDX_W-1:0]           wr_idx
);

    state_t                   state_q, state_d;
    logic [WORD_W-1:0]        word_q;
    logic [IDX_W-1:0]         idx_q;
    logic [WORD_W-1:0]        load_en;
    logic                     clear;
    logic                     accept;

    // A start in COLLECT wins over a digit presented in the same cycle.
    assign clear  = start && (state_q != FULL);
    assign accept = (state_q == COLLECT) && in_valid && !start;

    demux1to32_2bit u_demux (
        .idx     (idx_q),
        .en      (accept),
        .load_en (load_en)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: if (!start && in_valid && (idx_q == IDX_W'(SLOTS - 1)))
                         state_d = FULL;
            FULL:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The word is a plain 64-bit register, so reset clears it completely;
    // no partial word survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (clear) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            word_q <= (word_q & ~load_en) | ({SLOTS{in_data}} & load_en);
            idx_q  <= idx_q + IDX_W'(1);   // wraps to 0 after slot 31
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == FULL);
    assign out       = word_q;
    assign wr_idx    = idx_q;

endmodule : digit_collector_32x2
